// File: rtl/sel_sweep_pkg.sv
// Shared types and helpers for the selector sweep controller.
// Contents: the FSM state enum, the default parameter values, tw() (truth
// table width for n inputs) and lowest_set_idx() (index of the first
// mismatching truth-table bit).
package sel_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_IN_DEF          = 3;
  localparam int SETTLE_CYCLES_DEF = 2;
  // Widest truth table the mismatch search supports (N_IN up to 8).
  localparam int MAX_TW            = 256;

  function automatic int tw(input int n);
    return 32'sd1 << n;
  endfunction

  // Scan from the top down so that the last hit is the lowest set bit.
  // An all-zero vector yields 0.
  function automatic int lowest_set_idx(input logic [MAX_TW-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_TW - 1; i >= 0; i--) begin
      r = v[i] ? i : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_sweep_ctrl_if.sv
// Handshake and result bundle between the test/config master and the
// selector sweep controller.
//   master: drives start and expected; observes busy, done, pass,
//           table_o and first_fail.
//   slave : the controller side of the same signals.
interface sel_sweep_ctrl_if
  import sel_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) ();
  localparam int TW = tw(N_IN);

  logic            start;
  logic [TW-1:0]   expected;
  logic            busy;
  logic            done;
  logic            pass;
  logic [TW-1:0]   table_o;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, expected,
    input  busy, done, pass, table_o, first_fail
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, table_o, first_fail
  );
endinterface

// File: rtl/sel_sweep_settle_timer.sv
// Per-vector hold timer for the sweep controller.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : force the count back to 0 (wins over en)
//   en       : advance the count by one; it saturates at SETTLE_CYCLES-1
//   expired  : count has reached SETTLE_CYCLES-1 (last hold cycle)
module sel_sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CW-1:0] cnt_r;

  assign expired = (cnt_r == CW'(SETTLE_CYCLES - 1));

  // Hold counter: cleared between vectors, advanced while a vector settles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/sel_sweep_ctrl.sv
// Selector sweep controller: steps the 3-input evaluator through every
// input vector, holds each vector for SETTLE_CYCLES, samples L into a truth
// table, then compares that table against the expected table latched at
// start.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : start/expected in; busy/done/pass/table_o/first_fail out
//   abc_o    : vector to the evaluator; abc_o[N_IN-1] drives A, abc_o[0] drives C
//   l_i      : evaluator output L
// Optional build macro SEL_SWEEP_STOP_ON_FAIL_EN: when it is defined, the
// sweep aborts at the first vector whose L differs from the expected bit.
module sel_sweep_ctrl
  import sel_sweep_pkg::*;
#(
  parameter int N_IN          = N_IN_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sel_sweep_ctrl_if.slave       bus,
  output logic [N_IN-1:0]       abc_o,
  input  logic                  l_i
);
  localparam int TW = tw(N_IN);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("sel_sweep_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_nin
      $error("sel_sweep_ctrl: N_IN must be in 1..8");
    end
  endgenerate

  state_t          state_r;
  logic [N_IN-1:0] idx_r;
  logic [N_IN-1:0] abc_r;
  logic [TW-1:0]   exp_r;
  logic [TW-1:0]   tbl_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [N_IN-1:0] ff_r;

  logic              expired_s;
  logic              tmr_clr_s;
  logic              tmr_en_s;
  logic [TW-1:0]     tbl_next_s;
  logic [MAX_TW-1:0] mism_ext_s;

  assign tmr_en_s  = (state_r == SETTLE);
  assign tmr_clr_s = (state_r != SETTLE);

  sel_sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (expired_s)
  );

  // Table as it will look once the current sample has been written, so the
  // verdict registered with done already includes the last vector.
  always_comb begin
    tbl_next_s        = tbl_r;
    tbl_next_s[idx_r] = l_i;
    mism_ext_s             = {MAX_TW{1'b0}};
    mism_ext_s[TW-1:0]     = tbl_next_s ^ exp_r;
  end

`ifdef SEL_SWEEP_STOP_ON_FAIL_EN
  logic mismatch_now_s;
  assign mismatch_now_s = (l_i != exp_r[idx_r]);
`endif

  // Sweep sequencer: single-process FSM with every output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {N_IN{1'b0}};
      abc_r   <= {N_IN{1'b0}};
      exp_r   <= {TW{1'b0}};
      tbl_r   <= {TW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      ff_r    <= {N_IN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            exp_r   <= bus.expected;
            idx_r   <= {N_IN{1'b0}};
            abc_r   <= {N_IN{1'b0}};
            tbl_r   <= {TW{1'b0}};
            pass_r  <= 1'b0;
            ff_r    <= {N_IN{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SETTLE;
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (expired_s) begin
            state_r <= SAMPLE;
          end else begin
            state_r <= SETTLE;
          end
        end
        SAMPLE: begin
          tbl_r <= tbl_next_s;
`ifdef SEL_SWEEP_STOP_ON_FAIL_EN
          if (mismatch_now_s) begin
            busy_r  <= 1'b0;
            pass_r  <= 1'b0;
            ff_r    <= idx_r;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else
`endif
          if (idx_r == N_IN'(TW - 1)) begin
            busy_r  <= 1'b0;
            pass_r  <= (tbl_next_s == exp_r);
            ff_r    <= N_IN'(lowest_set_idx(mism_ext_s));
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + N_IN'(1);
            abc_r   <= idx_r + N_IN'(1);
            state_r <= SETTLE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          abc_r   <= {N_IN{1'b0}};
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign abc_o          = abc_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.table_o    = tbl_r;
  assign bus.first_fail = ff_r;
endmodule

// File: tb/tb_sel_sweep_ctrl.sv
// Self-checking bench for sel_sweep_ctrl: one instance with SETTLE_CYCLES=2
// and one with SETTLE_CYCLES=1, both fed by an evaluator model whose L is
// A^B^C, constant 1 or constant 0.
module tb_sel_sweep_ctrl;
  import sel_sweep_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sel_sweep_ctrl_if #(.N_IN(3)) bus2 ();
  sel_sweep_ctrl_if #(.N_IN(3)) bus1 ();

  logic [2:0] abc2, abc1;
  logic       l2, l1;
  int         sel_v;
  int         lmode;
  logic       start_v;
  logic [7:0] exp_v;

  assign bus2.start    = (sel_v == 2) ? start_v : 1'b0;
  assign bus1.start    = (sel_v == 1) ? start_v : 1'b0;
  assign bus2.expected = exp_v;
  assign bus1.expected = exp_v;

  // Evaluator model: 0 -> A^B^C, 1 -> L tied 1, 2 -> L tied 0.
  always_comb begin
    l2 = (lmode == 0) ? ^abc2 : (lmode == 1);
    l1 = (lmode == 0) ? ^abc1 : (lmode == 1);
  end

  sel_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2), .abc_o (abc2), .l_i (l2));
  sel_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .abc_o (abc1), .l_i (l1));

  logic [2:0] abc_m, ff_m;
  logic       busy_m, done_m, pass_m;
  logic [7:0] tbl_m;

  always_comb begin
    if (sel_v == 1) begin
      abc_m = abc1; ff_m = bus1.first_fail; busy_m = bus1.busy;
      done_m = bus1.done; pass_m = bus1.pass; tbl_m = bus1.table_o;
    end else begin
      abc_m = abc2; ff_m = bus2.first_fail; busy_m = bus2.busy;
      done_m = bus2.done; pass_m = bus2.pass; tbl_m = bus2.table_o;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] ff;
  } res_t;

  typedef struct {
    int         sel;
    int         lmode;
    logic [7:0] exp;
    logic [7:0] exp_mid;
    int         done_cyc;
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] ff;
  } row_t;

  row_t rows[6];
  res_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input int n);
    row_t r;
    res_t res;
    bit   seen;
    int   s;
    r       = rows[n];
    sel_v   = r.sel;
    lmode   = r.lmode;
    exp_v   = r.exp;
    s       = r.sel;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    sb_q.push_back('{tbl: r.tbl, pass: r.pass, ff: r.ff});
    seen = 1'b0;
    for (int cyc = 1; cyc <= r.done_cyc + 2; cyc++) begin
      if (cyc == 5) exp_v = r.exp_mid;
      if (cyc < r.done_cyc) begin
        chk($sformatf("row%0d abc c%0d", n, cyc), 32'(abc_m), 32'((cyc - 1) / (s + 1)));
        chk($sformatf("row%0d busy c%0d", n, cyc), 32'(busy_m), 32'd1);
      end
      chk($sformatf("row%0d done c%0d", n, cyc), 32'(done_m), 32'(cyc == r.done_cyc));
      if (done_m && !seen && (sb_q.size() > 0)) begin
        res  = sb_q.pop_front();
        seen = 1'b1;
        chk($sformatf("row%0d table", n), 32'(tbl_m), 32'(res.tbl));
        chk($sformatf("row%0d pass", n), 32'(pass_m), 32'(res.pass));
        chk($sformatf("row%0d first_fail", n), 32'(ff_m), 32'(res.ff));
        chk($sformatf("row%0d busy_at_done", n), 32'(busy_m), 32'd0);
      end
      if (cyc == r.done_cyc + 2) begin
        chk($sformatf("row%0d abc_idle", n), 32'(abc_m), 32'd0);
        chk($sformatf("row%0d table_hold", n), 32'(tbl_m), 32'(r.tbl));
        chk($sformatf("row%0d pass_hold", n), 32'(pass_m), 32'(r.pass));
      end
      tick();
    end
    if (!seen) begin
      chk($sformatf("row%0d done_timeout", n), 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  int dones;

  initial begin
    errors  = 0;
    checks  = 0;
    sel_v   = 2;
    lmode   = 0;
    start_v = 1'b0;
    exp_v   = 8'h00;
    rst     = 1'b1;

    // sel, lmode, expected, expected from cycle 5, done cycle, table, pass, first_fail
    rows[0] = '{2, 0, 8'h96, 8'h96, 25, 8'h96, 1'b1, 3'd0};
`ifdef SEL_SWEEP_STOP_ON_FAIL_EN
    rows[1] = '{2, 0, 8'h97, 8'h97,  4, 8'h00, 1'b0, 3'd0};
`else
    rows[1] = '{2, 0, 8'h97, 8'h97, 25, 8'h96, 1'b0, 3'd0};
`endif
    rows[2] = '{1, 1, 8'hFF, 8'hFF, 17, 8'hFF, 1'b1, 3'd0};
`ifdef SEL_SWEEP_STOP_ON_FAIL_EN
    rows[3] = '{2, 2, 8'h96, 8'h96,  7, 8'h00, 1'b0, 3'd1};
`else
    rows[3] = '{2, 2, 8'h96, 8'h96, 25, 8'h00, 1'b0, 3'd1};
`endif
    rows[4] = '{1, 0, 8'h96, 8'h00, 17, 8'h96, 1'b1, 3'd0};
    rows[5] = '{2, 0, 8'h16, 8'h16, 25, 8'h96, 1'b0, 3'd7};

    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset busy", 32'(bus2.busy), 32'd0);
    chk("reset done", 32'(bus2.done), 32'd0);
    chk("reset pass", 32'(bus2.pass), 32'd0);
    chk("reset table", 32'(bus2.table_o), 32'd0);
    chk("reset first_fail", 32'(bus2.first_fail), 32'd0);
    chk("reset abc", 32'(abc2), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_row(i);
    end

    // start held for 30 cycles: one sweep, then a second accepted from IDLE.
    sel_v   = 2;
    lmode   = 0;
    exp_v   = 8'h96;
    start_v = 1'b1;
    tick();
    dones = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (done_m) dones++;
      if (cyc == 25) chk("held pass", 32'(pass_m), 32'd1);
      if (cyc == 25) chk("held done", 32'(done_m), 32'd1);
      if (cyc == 26) chk("held idle busy", 32'(busy_m), 32'd0);
      if (cyc == 27) chk("held restart busy", 32'(busy_m), 32'd1);
      if (cyc == 29) start_v = 1'b0;
      tick();
    end
    chk("held done count", 32'(dones), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset in cycle 10 of a sweep.
    sel_v   = 2;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    dones   = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (done_m) dones++;
      if (cyc == 10) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    chk("midrst abc", 32'(abc_m), 32'd0);
    chk("midrst busy", 32'(busy_m), 32'd0);
    chk("midrst table", 32'(tbl_m), 32'd0);
    chk("midrst done", 32'(done_m), 32'd0);
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (done_m) dones++;
      tick();
    end
    chk("midrst no done", 32'(dones), 32'd0);
    run_row(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
